mode_counter: RTL and testbench

Parametrised multi-mode counter; generalised successor of the project's fixed free-running counter. Adds programmable width, a prescaler, up/down counting, four terminal-count modes, synchronous load, compare match and a sticky overflow flag. It is instantiated in the Tiny Tapeout top: `count` drives `uo_out`, and the control inputs come from `ui_in` and `uio_in`.

---
 rtl/counter_pkg.sv | 14 +
 rtl/prescaler.sv | 37 +++
 rtl/mode_counter.sv | 124 ++++++++++++
 tb/tb_mode_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default sizes for the multi-mode counter.
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'b00,
        SAT      = 2'b01,
        ONESHOT  = 2'b10,
        PINGPONG = 2'b11
    } cnt_mode_t;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_PRESC_W = 4;

endpackage

// File: rtl/prescaler.sv
// Enable-gated prescaler: strobes tick every div+1 enabled cycles.
module prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] pq_q, pq_d;

    assign tick = en && (pq_q == div);

    // Lowering div below pq just lets the increment wrap around to it.
    always_comb begin
        pq_d = pq_q;
        if (clr || tick) begin
            pq_d = '0;
        end else if (en) begin
            pq_d = pq_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pq_q <= '0;
        end else begin
            pq_q <= pq_d;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter: WRAP / SAT / ONESHOT / PINGPONG terminal behaviour,
// prescaled stepping, synchronous load, compare match and sticky overflow.
module mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic               ovf_clr,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               tc,
    output logic               cmp_match,
    output logic               ovf,
    output logic               running
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             running_q, running_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    cnt_mode_t mode_m;
    logic      eff_dir;
    logic      at_term;
    logic      step_en;
    logic      term_evt;

    prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .div  (presc_div),
        .tick (tick)
    );

    assign mode_m   = cnt_mode_t'(mode);
    assign eff_dir  = (mode_m == PINGPONG) ? dir_q : dir;
    assign at_term  = eff_dir ? (count_q == MAX) : (count_q == '0);
    // A disarmed one-shot swallows ticks entirely, so no terminal event either.
    assign step_en  = tick && !load && !((mode_m == ONESHOT) && !running_q);
    assign term_evt = step_en && at_term;

    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        running_d = running_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q;

        if (load) begin
            count_d   = load_val;
            dir_d     = dir;
            running_d = 1'b1;
        end else begin
            if (step_en) begin
                if (!at_term) begin
                    count_d = eff_dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end else begin
                    case (mode_m)
                        WRAP:     count_d = eff_dir ? '0 : MAX;
                        SAT:      count_d = count_q;
                        ONESHOT:  running_d = 1'b0;
                        PINGPONG: begin
                            dir_d   = ~dir_q;
                            // At MAX going up we step down, at 0 going down we step up.
                            count_d = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                        end
                        default:  count_d = count_q;
                    endcase
                end
            end

            tc_d = term_evt;
            if (term_evt) begin
                ovf_d = 1'b1;
            end else if (ovf_clr) begin
                ovf_d = 1'b0;
            end

            if (mode_m != ONESHOT) begin
                running_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            dir_q     <= 1'b1;
            running_q <= 1'b1;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign running   = running_q;
    assign cmp_match = (count_q == cmp_val);

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter at WIDTH=4, PRESC_W=4.
module tb_mode_counter;

    localparam int W    = 4;
    localparam int P    = 4;
    localparam int MAXV = 15;

    logic         clk = 1'b0;
    logic         rst, en, dir, load, ovf_clr;
    logic [1:0]   mode;
    logic [P-1:0] presc_div;
    logic [W-1:0] load_val, cmp_val;
    logic [W-1:0] count;
    logic         tick, tc, cmp_match, ovf, running;

    mode_counter #(.WIDTH(W), .PRESC_W(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .presc_div (presc_div),
        .load      (load),
        .load_val  (load_val),
        .cmp_val   (cmp_val),
        .ovf_clr   (ovf_clr),
        .count     (count),
        .tick      (tick),
        .tc        (tc),
        .cmp_match (cmp_match),
        .ovf       (ovf),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        bit run;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int  m_count = 0, m_pq = 0;
    bit  m_tc = 0, m_ovf = 0, m_dir = 1, m_run = 1;
    bit  m_valid = 0;
    int  n_cmp_hits;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict, then compare after the edge.
    task automatic cyc(input bit r, input bit e, input bit d, input int md, input int div,
                       input bit ld, input int lv, input bit oc);
        bit   tk, ed;
        exp_t x;
        @(negedge clk);
        rst = r; en = e; dir = d; mode = 2'(md); presc_div = P'(div);
        load = ld; load_val = W'(lv); ovf_clr = oc;
        #1;
        tk = e && (m_pq == div);
        if (m_valid) begin
            check("tick", tick, tk);
            check("cmp_match", cmp_match, (m_count == int'(cmp_val)));
        end
        if (cmp_match) n_cmp_hits++;

        if (r) begin
            m_count = 0; m_pq = 0; m_tc = 0; m_ovf = 0; m_dir = 1; m_run = 1;
        end else if (ld) begin
            m_count = lv; m_pq = 0; m_run = 1; m_dir = d; m_tc = 0;
        end else begin
            m_pq = tk ? 0 : (e ? (m_pq + 1) % (1 << P) : m_pq);
            ed = (md == 3) ? m_dir : d;
            m_tc = 0;
            if (tk && !(md == 2 && !m_run)) begin
                if ((ed && m_count == MAXV) || (!ed && m_count == 0)) begin
                    m_tc = 1;
                    m_ovf = 1;
                    if (md == 0) m_count = ed ? 0 : MAXV;
                    else if (md == 2) m_run = 0;
                    else if (md == 3) begin
                        m_dir = !m_dir;
                        m_count = ed ? MAXV - 1 : 1;
                    end
                end else begin
                    m_count = ed ? m_count + 1 : m_count - 1;
                    if (oc) m_ovf = 0;
                end
            end else if (oc) begin
                m_ovf = 0;
            end
            if (md != 2) m_run = 1;
        end
        if (r) m_valid = 1;
        x.cnt = m_count; x.tc = m_tc; x.ovf = m_ovf; x.run = m_run;
        exp_q.push_back(x);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            x = exp_q.pop_front();
            check("count", count, x.cnt);
            check("tc", tc, x.tc);
            check("ovf", ovf, x.ovf);
            check("running", running, x.run);
        end
    endtask

    initial begin
        rst = 1; en = 0; dir = 1; mode = 0; presc_div = 0; load = 0;
        load_val = 0; cmp_val = 0; ovf_clr = 0;

        // Reset state
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        check("rst_count", count, 0);
        check("rst_tc", tc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_running", running, 1);

        // WRAP up, tick every cycle: 1..15, 0 with tc on return to 0
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 0);
            check("wrap_seq", count, (i + 1) % 16);
        end
        check("wrap_tc", tc, 1);
        check("wrap_ovf", ovf, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 1);
        check("wrap_tc_one_cycle", tc, 0);
        check("ovf_cleared", ovf, 0);

        // SAT down from 2 with prescale 3
        cyc(0, 1, 0, 1, 2, 1, 2, 0);
        for (int i = 0; i < 18; i++) cyc(0, 1, 0, 1, 2, 0, 0, 0);
        check("sat_hold", count, 0);

        // ONESHOT up from 13, then re-arm
        cyc(0, 1, 1, 2, 0, 1, 13, 1);
        for (int i = 0; i < 14; i++) cyc(0, 1, 1, 2, 0, 0, 0, 0);
        check("oneshot_hold", count, 15);
        check("oneshot_disarmed", running, 0);
        cyc(0, 1, 1, 2, 0, 1, 13, 0);
        check("oneshot_rearm", running, 1);
        cyc(0, 1, 1, 2, 0, 0, 0, 0);

        // PINGPONG from 0 up; dir input ignored while counting
        cyc(0, 1, 1, 3, 0, 1, 0, 0);
        for (int i = 0; i < 34; i++) cyc(0, 1, 0, 3, 0, 0, 0, 0);
        check("pingpong_end", count, 4);

        // Load + tick + ovf_clr with ovf already set: load wins, ovf held
        check("ovf_before_load", ovf, 1);
        cyc(0, 1, 1, 0, 0, 1, 9, 1);
        check("load_wins", count, 9);
        check("load_keeps_ovf", ovf, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 7, 0);
        check("midrst_count", count, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_running", running, 1);

        // Compare match: exactly once per wrap period
        cmp_val = 5;
        cyc(0, 1, 1, 0, 0, 1, 0, 0);
        n_cmp_hits = 0;
        for (int i = 0; i < 32; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
        check("cmp_hits", n_cmp_hits, 2);

        // Lower prescale divisor below current pq: wraps, no lockup
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 6, 0, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 1, 1, 0, 1, 0, 0, 0);

        // Randomised mix against the model
        for (int i = 0; i < 400; i++) begin
            cmp_val = W'($urandom_range(0, MAXV));
            cyc($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 25) == 0,
                $urandom_range(0, MAXV), $urandom_range(0, 10) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
